// File: rtl/rv32m_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32m_div_unit_pkg
// Purpose  : Shared op/state encodings for the RV32M divider, decoder and
//            hazard unit.
// Revision : 1.0 - initial release
// ============================================================================
package rv32m_div_unit_pkg;

    localparam int XLEN_DEFAULT = 32;

    // Matches funct3[1:0] of the M-extension divide group
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_SIGN = 2'b10,
        ST_DONE = 2'b11
    } div_state_e;

endpackage : rv32m_div_unit_pkg
`default_nettype wire

// File: rtl/rv32m_div_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : rv32m_div_unit_if
// Purpose  : Request/response bundle between the EX stage and the divider.
// Revision : 1.0 - initial release
// ============================================================================
interface rv32m_div_unit_if
    import rv32m_div_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            flush;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, dividend, divisor, flush,
        input  busy, stall, done, result
    );

    modport slave (
        input  start, op, dividend, divisor, flush,
        output busy, stall, done, result
    );
endinterface : rv32m_div_unit_if
`default_nettype wire

// File: rtl/rv32m_div_unit_div_step.sv
`default_nettype none
// ============================================================================
// Module   : rv32m_div_unit_div_step
// Purpose  : One combinational restoring-division iteration.
// Revision : 1.0 - initial release
// ============================================================================
module rv32m_div_unit_div_step #(
    parameter int XLEN = 32
) (
    input  wire logic [XLEN-1:0] i_rem,
    input  wire logic [XLEN-1:0] i_q,
    input  wire logic [XLEN-1:0] i_divisor,
    output logic      [XLEN-1:0] o_rem_next,
    output logic      [XLEN-1:0] o_q_next
);
    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;
    logic          w_ge;

    // Shifted remainder keeps its carry bit so divisors above 2^(XLEN-1) work
    assign w_shift    = {i_rem, i_q[XLEN-1]};
    assign w_diff     = w_shift - {1'b0, i_divisor};
    assign w_ge       = ~w_diff[XLEN];
    assign o_rem_next = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    assign o_q_next   = {i_q[XLEN-2:0], w_ge};
endmodule : rv32m_div_unit_div_step
`default_nettype wire

// File: rtl/rv32m_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : rv32m_div_unit
// Purpose  : Iterative RV32M DIV/DIVU/REM/REMU unit, one bit per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module rv32m_div_unit
    import rv32m_div_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  wire logic          clk,
    input  wire logic          rst,
    rv32m_div_unit_if.slave    bus
);
    localparam int              c_cnt_w   = $clog2(XLEN);
    localparam logic [XLEN-1:0] c_int_min = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e        r_state;
    div_state_e        w_state_next;
    div_op_e           r_op;
    logic [XLEN-1:0]   r_q;
    logic [XLEN-1:0]   r_dvs;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_result;
    logic [c_cnt_w-1:0] r_cnt;
    logic              r_neg_q;
    logic              r_dvd_neg;
    logic              r_divz;
    logic              r_ovf;

    logic              w_idle_or_done;
    logic              w_accept;
    logic              w_signed;
    logic              w_dvd_neg;
    logic              w_dvs_neg;
    logic              w_divz;
    logic              w_ovf;
    logic              w_last;
    logic [XLEN-1:0]   w_dvd_abs;
    logic [XLEN-1:0]   w_dvs_abs;
    logic [XLEN-1:0]   w_rem_next;
    logic [XLEN-1:0]   w_q_next;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_remd;
    logic [XLEN-1:0]   w_result;

    assign w_idle_or_done = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_accept       = bus.start & w_idle_or_done & ~bus.flush;
    assign w_signed       = ~bus.op[0];
    assign w_dvd_neg      = w_signed & bus.dividend[XLEN-1];
    assign w_dvs_neg      = w_signed & bus.divisor[XLEN-1];
    assign w_dvd_abs      = w_dvd_neg ? -bus.dividend : bus.dividend;
    assign w_dvs_abs      = w_dvs_neg ? -bus.divisor  : bus.divisor;
    assign w_divz         = (bus.divisor == '0);
    assign w_ovf          = w_signed & (bus.dividend == c_int_min) & (bus.divisor == '1);
    assign w_last         = (r_cnt == c_cnt_w'(XLEN - 1));

    rv32m_div_unit_div_step #(
        .XLEN (XLEN)
    ) u_div_step (
        .i_rem      (r_rem),
        .i_q        (r_q),
        .i_divisor  (r_dvs),
        .o_rem_next (w_rem_next),
        .o_q_next   (w_q_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (bus.flush) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        w_state_next = (w_divz || w_ovf) ? ST_SIGN : ST_CALC;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (w_last) begin
                        w_state_next = ST_SIGN;
                    end
                end
                ST_SIGN: w_state_next = ST_DONE;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Special cases never iterate, so r_q still holds |dividend| in SIGN
    always_comb begin
        w_quot = r_neg_q   ? -r_q   : r_q;
        w_remd = r_dvd_neg ? -r_rem : r_rem;
        if (r_divz) begin
            w_quot = '1;
            w_remd = r_dvd_neg ? -r_q : r_q;
        end else if (r_ovf) begin
            w_quot = c_int_min;
            w_remd = '0;
        end
        w_result = ((r_op == OP_REM) || (r_op == OP_REMU)) ? w_remd : w_quot;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op      <= OP_DIV;
            r_q       <= '0;
            r_dvs     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_neg_q   <= 1'b0;
            r_dvd_neg <= 1'b0;
            r_divz    <= 1'b0;
            r_ovf     <= 1'b0;
            r_result  <= '0;
        end else begin
            if (w_accept) begin
                r_op      <= div_op_e'(bus.op);
                r_q       <= w_dvd_abs;
                r_dvs     <= w_dvs_abs;
                r_rem     <= '0;
                r_cnt     <= '0;
                r_neg_q   <= w_dvd_neg ^ w_dvs_neg;
                r_dvd_neg <= w_dvd_neg;
                r_divz    <= w_divz;
                r_ovf     <= w_ovf;
            end else if ((r_state == ST_CALC) && !bus.flush) begin
                r_rem <= w_rem_next;
                r_q   <= w_q_next;
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
            if ((r_state == ST_SIGN) && !bus.flush) begin
                r_result <= w_result;
            end
        end
    end

    assign bus.busy   = (r_state == ST_CALC) || (r_state == ST_SIGN);
    assign bus.done   = (r_state == ST_DONE);
    assign bus.stall  = w_accept | bus.busy;
    assign bus.result = r_result;
endmodule : rv32m_div_unit
`default_nettype wire

// File: tb/tb_rv32m_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32m_div_unit
// Purpose  : Directed self-checking bench for rv32m_div_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32m_div_unit;
    localparam int XLEN = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    rv32m_div_unit_if #(.XLEN(XLEN)) bus ();

    rv32m_div_unit #(
        .XLEN (XLEN)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // RISC-V divide semantics straight from the ISA rules
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic is_rem;
        logic sgn;
        is_rem = op[1];
        sgn    = !op[0];
        if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return is_rem ? 32'd0 : 32'h8000_0000;
        if (sgn) begin
            if (is_rem) return $signed(a) % $signed(b);
            else        return $signed(a) / $signed(b);
        end
        if (is_rem) return a % b;
        return a / b;
    endfunction

    function automatic bit is_special(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Latency model: cycles remaining until done, result committed at done
    int          m_left;
    logic        m_done;
    logic [31:0] m_result;
    logic [31:0] m_pending;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left    <= 0;
            m_done    <= 1'b0;
            m_result  <= '0;
            m_pending <= '0;
        end else if (bus.flush) begin
            m_left <= 0;
            m_done <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done   <= 1'b1;
                m_result <= m_pending;
            end
        end else begin
            m_done <= 1'b0;
            if (bus.start) begin
                m_pending <= ref_div(bus.op, bus.dividend, bus.divisor);
                m_left    <= is_special(bus.op, bus.dividend, bus.divisor) ? 1 : XLEN + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy",   {31'd0, bus.busy}, {31'd0, m_left > 0});
            chk("done",   {31'd0, bus.done}, {31'd0, m_done});
            chk("stall",  {31'd0, bus.stall},
                {31'd0, (bus.start && m_left == 0 && !bus.flush) || (m_left > 0)});
            chk("result", bus.result, m_result);
        end
    end

    // Drives one op from the current slot (chain=1: already inside a DONE cycle)
    task automatic do_op(input string name, input bit chain, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat, input int inject_cyc);
        int cyc;
        if (!chain) begin
            @(posedge clk);
            #2;
        end
        bus.start    = 1'b1;
        bus.op       = op;
        bus.dividend = a;
        bus.divisor  = b;
        #1;
        chk({name, "_stall0"}, {31'd0, bus.stall}, 32'd1);
        cyc = 0;
        while (cyc < 100) begin
            @(posedge clk);
            #2;
            cyc++;
            bus.start = 1'b0;
            if (cyc == inject_cyc) begin
                bus.start    = 1'b1;
                bus.op       = 2'b01;
                bus.dividend = 32'd77;
                bus.divisor  = 32'd11;
            end
            if (bus.done) break;
        end
        chk({name, "_lat"},   cyc, exp_lat);
        chk({name, "_res"},   bus.result, exp);
        chk({name, "_model"}, m_result, exp);
    endtask

    initial begin
        int cyc;
        bit seen;
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.op       = 2'b00;
        bus.dividend = '0;
        bus.divisor  = '0;
        bus.flush    = 1'b0;
        #8;
        chk("rst_busy",   {31'd0, bus.busy},  32'd0);
        chk("rst_done",   {31'd0, bus.done},  32'd0);
        chk("rst_stall",  {31'd0, bus.stall}, 32'd0);
        chk("rst_result", bus.result,         32'd0);
        #4;
        rst = 1'b0;

        do_op("divu_100_7",  0, 2'b01, 32'd100,       32'd7,         32'd14,        34, -1);
        do_op("remu_100_7",  0, 2'b11, 32'd100,       32'd7,         32'd2,         34, -1);
        do_op("div_m7_2",    0, 2'b00, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, -1);
        do_op("rem_m7_2",    0, 2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, -1);
        do_op("rem_7_m2",    0, 2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         34, -1);
        do_op("divu_5_0",    0, 2'b01, 32'd5,         32'd0,         32'hFFFF_FFFF,  2, -1);
        do_op("rem_5_0",     0, 2'b10, 32'd5,         32'd0,         32'd5,          2, -1);
        do_op("rem_m7_0",    0, 2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9,  2, -1);
        do_op("div_ovf",     0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,  2, -1);
        do_op("rem_ovf",     0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,          2, -1);
        do_op("divu_min_m1", 0, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         34, -1);
        do_op("divu_bigdvs", 0, 2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1,         34, -1);
        do_op("remu_bigdvs", 0, 2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 34, -1);

        // Flush in cycle 10 of a normal run
        @(posedge clk);
        #2;
        bus.start    = 1'b1;
        bus.op       = 2'b01;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        for (int i = 1; i <= 11; i++) begin
            @(posedge clk);
            #2;
            bus.start = 1'b0;
            bus.flush = (i == 10);
        end
        chk("flush_busy",   {31'd0, bus.busy}, 32'd0);
        chk("flush_done",   {31'd0, bus.done}, 32'd0);
        chk("flush_result", bus.result,        32'h7FFF_FFFE);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #2;
            if (bus.done) seen = 1'b1;
        end
        chk("flush_no_done", {31'd0, seen}, 32'd0);

        do_op("ignored_start", 0, 2'b01, 32'd1000, 32'd10, 32'd100, 34, 5);
        do_op("b2b_first",     0, 2'b01, 32'd100,  32'd7,  32'd14,  34, -1);
        do_op("b2b_second",    1, 2'b11, 32'd9,    32'd4,  32'd1,   34, -1);

        // Asynchronous reset in cycle 15 of a normal run
        @(posedge clk);
        #2;
        bus.start    = 1'b1;
        bus.op       = 2'b01;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        cyc = 0;
        while (cyc < 15) begin
            @(posedge clk);
            #2;
            bus.start = 1'b0;
            cyc++;
        end
        #1;
        rst = 1'b1;
        #1;
        chk("arst_busy",   {31'd0, bus.busy}, 32'd0);
        chk("arst_done",   {31'd0, bus.done}, 32'd0);
        chk("arst_result", bus.result,        32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        do_op("after_rst", 0, 2'b01, 32'd9, 32'd3, 32'd3, 34, -1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule : tb_rv32m_div_unit
`default_nettype wire
